pong_ball_engine: RTL and testbench

Parametrised, frame-tick-driven ball physics engine for the Pong game pipeline. It takes the left and right paddle positions from the input/controller logic and maintains the ball position and signed velocity. It resolves bounces off the top and bottom walls and off the paddles, and detects misses. It keeps per-player score counters and a serve/freeze state machine, and feeds the renderer and the score display.

---
 rtl/pong_pkg.sv | 7 +
 rtl/pong_wall_reflect.sv | 22 ++
 rtl/pong_ball_engine.sv | 134 +++++++++++++
 tb/tb_pong_ball_engine.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pong_pkg.sv
// pong_pkg: shared FSM state, velocity type and serve-direction codes for the pong ball engine
package pong_pkg;
  typedef enum logic [1:0] {IDLE, RUN, SCORED} state_t;
  typedef logic signed [7:0] vel_t;
  localparam logic DIR_POS = 1'b0;
  localparam logic DIR_NEG = 1'b1;
endpackage

// File: rtl/pong_wall_reflect.sv
// pong_wall_reflect: Y step with clamp to 0..SCREEN_H-1 and vy reflect; in y/vy, out y_out/vy_out/bounce
module pong_wall_reflect #(
  parameter int Y_W = 16,
  parameter int V_W = 8,
  parameter int SCREEN_H = 480
) (
  input  logic [Y_W-1:0]        y,
  input  logic signed [V_W-1:0] vy,
  output logic [Y_W-1:0]        y_out,
  output logic signed [V_W-1:0] vy_out,
  output logic                  bounce
);
  localparam logic signed [Y_W:0] Y_MAX = (Y_W+1)'(SCREEN_H - 1);
  logic signed [Y_W:0] ny;
  logic lo, hi;
  assign ny = $signed({1'b0, y}) + (Y_W+1)'(vy);
  assign lo = ny[Y_W];
  assign hi = ny > Y_MAX;
  assign bounce = lo || hi;
  assign y_out = lo ? '0 : hi ? Y_W'(SCREEN_H - 1) : ny[Y_W-1:0];
  assign vy_out = bounce ? -vy : vy;
endmodule

// File: rtl/pong_ball_engine.sv
// pong_ball_engine: frame-tick ball physics, paddle hits, misses, scores, serve FSM; in clk/rst(active-low sync)/frame_tick/serve/paddle y, out ball pos/vel/pulses/scores/running; PONG_SPEEDUP_EN adds +1 |vx| per paddle hit
module pong_ball_engine
  import pong_pkg::*;
#(
  parameter int X_W = 16,
  parameter int Y_W = 16,
  parameter int V_W = 8,
  parameter int SCREEN_H = 480,
  parameter int CENTER_X = 320,
  parameter int CENTER_Y = 240,
  parameter int LEFT_X = 16,
  parameter int RIGHT_X = 623,
  parameter int PADDLE_H = 64,
  parameter int INIT_VX = 2,
  parameter int INIT_VY = 1,
  parameter int MAX_VX = 8,
  parameter int SCORE_W = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  frame_tick,
  input  logic                  serve,
  input  logic [Y_W-1:0]        left_paddle_y,
  input  logic [Y_W-1:0]        right_paddle_y,
  output logic [X_W-1:0]        ball_x,
  output logic [Y_W-1:0]        ball_y,
  output logic signed [V_W-1:0] vel_x,
  output logic signed [V_W-1:0] vel_y,
  output logic                  update_valid,
  output logic                  hit_left,
  output logic                  hit_right,
  output logic                  wall_hit,
  output logic [SCORE_W-1:0]    score_left,
  output logic [SCORE_W-1:0]    score_right,
  output logic                  running
);
`ifdef PONG_SPEEDUP_EN
  localparam bit SPEEDUP = 1'b1;
`else
  localparam bit SPEEDUP = 1'b0;
`endif
  localparam logic signed [X_W:0] LX = (X_W+1)'(LEFT_X);
  localparam logic signed [X_W:0] RX = (X_W+1)'(RIGHT_X);
  localparam logic signed [V_W-1:0] VMAX = V_W'(MAX_VX);
  localparam logic signed [V_W-1:0] VINIT = V_W'(INIT_VX);
  localparam logic [Y_W:0] PH = (Y_W+1)'(PADDLE_H - 1);
  state_t state, state_nx;
  logic dir, dir_nx;
  logic signed [X_W:0] nx;
  logic [Y_W-1:0] wy, y_nx;
  logic [X_W-1:0] x_nx;
  logic signed [V_W-1:0] wvy, mag, mag_up, vx_bounce, vx_nx, vy_nx;
  logic [SCORE_W-1:0] sl_nx, sr_nx;
  logic wbounce, tick, l_cross, r_cross, l_win, r_win, l_hit, r_hit, l_miss, r_miss, miss, wh_nx;
  pong_wall_reflect #(.Y_W(Y_W), .V_W(V_W), .SCREEN_H(SCREEN_H)) u_wall (
    .y(ball_y),
    .vy(vel_y),
    .y_out(wy),
    .vy_out(wvy),
    .bounce(wbounce)
  );
  assign tick = state == RUN && frame_tick;
  assign nx = $signed({1'b0, ball_x}) + (X_W+1)'(vel_x);
  assign l_cross = vel_x[V_W-1] && nx <= LX;
  assign r_cross = !vel_x[V_W-1] && vel_x != '0 && nx >= RX;
  // paddle window is tested against the wall-corrected y, one guard bit avoids wrap of paddle_y + PADDLE_H - 1
  assign l_win = {1'b0, left_paddle_y} <= {1'b0, wy} && {1'b0, wy} <= {1'b0, left_paddle_y} + PH;
  assign r_win = {1'b0, right_paddle_y} <= {1'b0, wy} && {1'b0, wy} <= {1'b0, right_paddle_y} + PH;
  assign l_hit = l_cross && l_win;
  assign r_hit = r_cross && r_win;
  assign l_miss = l_cross && !l_win;
  assign r_miss = r_cross && !r_win;
  assign miss = l_miss || r_miss;
  assign mag = vel_x[V_W-1] ? -vel_x : vel_x;
  assign mag_up = mag >= VMAX ? VMAX : mag + V_W'(1);
  // speed-up grows the magnitude first, then the sign is flipped away from the paddle
  assign vx_bounce = SPEEDUP ? (vel_x[V_W-1] ? mag_up : -mag_up) : -vel_x;
  assign wh_nx = tick && !miss && wbounce;
  always_ff @(posedge clk) state <= !rst ? IDLE : state_nx;
  always_comb state_nx = state == RUN ? (tick && miss ? SCORED : RUN) : (serve ? RUN : state);
  always_comb begin
    x_nx = ball_x;
    y_nx = ball_y;
    vx_nx = vel_x;
    vy_nx = vel_y;
    sl_nx = score_left;
    sr_nx = score_right;
    dir_nx = dir;
    if (state != RUN && serve) begin
      x_nx = X_W'(CENTER_X);
      y_nx = Y_W'(CENTER_Y);
      vx_nx = dir == DIR_NEG ? -VINIT : VINIT;
      vy_nx = V_W'(INIT_VY);
    end else if (tick && miss) begin
      sr_nx = l_miss ? score_right + SCORE_W'(!(&score_right)) : score_right;
      sl_nx = r_miss ? score_left + SCORE_W'(!(&score_left)) : score_left;
      dir_nx = l_miss ? DIR_NEG : DIR_POS;
    end else if (tick) begin
      x_nx = l_hit ? X_W'(LEFT_X) : r_hit ? X_W'(RIGHT_X) : nx[X_W-1:0];
      vx_nx = l_hit || r_hit ? vx_bounce : vel_x;
      y_nx = wy;
      vy_nx = wvy;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      ball_x <= X_W'(CENTER_X);
      ball_y <= Y_W'(CENTER_Y);
      vel_x <= '0;
      vel_y <= '0;
      score_left <= '0;
      score_right <= '0;
      update_valid <= 1'b0;
      hit_left <= 1'b0;
      hit_right <= 1'b0;
      wall_hit <= 1'b0;
      running <= 1'b0;
      dir <= DIR_POS;
    end else begin
      ball_x <= x_nx;
      ball_y <= y_nx;
      vel_x <= vx_nx;
      vel_y <= vy_nx;
      score_left <= sl_nx;
      score_right <= sr_nx;
      update_valid <= tick;
      hit_left <= tick && l_hit;
      hit_right <= tick && r_hit;
      wall_hit <= wh_nx;
      running <= state_nx == RUN;
      dir <= dir_nx;
    end
  end
endmodule

// File: tb/tb_pong_ball_engine.sv
// tb_pong_ball_engine: directed bench with an integer reference model checked every cycle plus literal pins
module tb_pong_ball_engine;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic frame_tick = 1'b0;
  logic serve = 1'b0;
  logic [15:0] left_paddle_y = '0;
  logic [15:0] right_paddle_y = '0;
  logic [15:0] ball_x, ball_y;
  logic signed [7:0] vel_x, vel_y;
  logic update_valid, hit_left, hit_right, wall_hit, running;
  logic [3:0] score_left, score_right;
  int n_tests = 0;
  int n_fail = 0;
  bit chk_en = 0;
  bit follow_l = 1;
  bit follow_r = 1;
  int e_x = 320, e_y = 240, e_vx = 0, e_vy = 0, e_sl = 0, e_sr = 0, e_dir = 1;
  bit e_run = 0, e_uv = 0, e_hl = 0, e_hr = 0, e_wh = 0;

  pong_ball_engine dut (
    .clk(clk), .rst(rst), .frame_tick(frame_tick), .serve(serve),
    .left_paddle_y(left_paddle_y), .right_paddle_y(right_paddle_y),
    .ball_x(ball_x), .ball_y(ball_y), .vel_x(vel_x), .vel_y(vel_y),
    .update_valid(update_valid), .hit_left(hit_left), .hit_right(hit_right),
    .wall_hit(wall_hit), .score_left(score_left), .score_right(score_right),
    .running(running)
  );

  always #5 clk = ~clk;

  function automatic int bounce_v(input int vx);
    int m;
    m = vx < 0 ? -vx : vx;
`ifdef PONG_SPEEDUP_EN
    m = m + 1 > 8 ? 8 : m + 1;
`endif
    return vx < 0 ? m : -m;
  endfunction

  always @(posedge clk) begin : model
    int nx, ny, nvy;
    bit wh, lw, rw, lc, rc;
    if (!rst) begin
      e_x = 320; e_y = 240; e_vx = 0; e_vy = 0; e_sl = 0; e_sr = 0; e_dir = 1;
      e_run = 0; e_uv = 0; e_hl = 0; e_hr = 0; e_wh = 0;
    end else begin
      e_uv = 0; e_hl = 0; e_hr = 0; e_wh = 0;
      if (!e_run) begin
        if (serve) begin
          e_x = 320; e_y = 240; e_vx = 2 * e_dir; e_vy = 1; e_run = 1;
        end
      end else if (frame_tick) begin
        e_uv = 1;
        nx = e_x + e_vx;
        ny = e_y + e_vy;
        nvy = e_vy;
        wh = 0;
        if (ny < 0) begin ny = 0; nvy = -e_vy; wh = 1; end
        else if (ny > 479) begin ny = 479; nvy = -e_vy; wh = 1; end
        lw = ny >= int'(left_paddle_y) && ny <= int'(left_paddle_y) + 63;
        rw = ny >= int'(right_paddle_y) && ny <= int'(right_paddle_y) + 63;
        lc = e_vx < 0 && nx <= 16;
        rc = e_vx > 0 && nx >= 623;
        if (lc && !lw) begin
          e_sr = e_sr < 15 ? e_sr + 1 : 15; e_run = 0; e_dir = -1;
        end else if (rc && !rw) begin
          e_sl = e_sl < 15 ? e_sl + 1 : 15; e_run = 0; e_dir = 1;
        end else begin
          if (lc) begin nx = 16; e_vx = bounce_v(e_vx); e_hl = 1; end
          else if (rc) begin nx = 623; e_vx = bounce_v(e_vx); e_hr = 1; end
          e_x = nx; e_y = ny; e_vy = nvy; e_wh = wh;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      n_tests++;
      if (ball_x !== 16'(e_x) || ball_y !== 16'(e_y) || vel_x !== 8'(e_vx) || vel_y !== 8'(e_vy) ||
          update_valid !== e_uv || hit_left !== e_hl || hit_right !== e_hr || wall_hit !== e_wh ||
          score_left !== 4'(e_sl) || score_right !== 4'(e_sr) || running !== e_run) begin
        n_fail++;
        $display("FAIL cycle_model t=%0t got pos=(%0d,%0d) vel=(%0d,%0d) uv=%b hl=%b hr=%b wh=%b sc=%0d/%0d run=%b expected pos=(%0d,%0d) vel=(%0d,%0d) uv=%b hl=%b hr=%b wh=%b sc=%0d/%0d run=%b",
                 $time, ball_x, ball_y, vel_x, vel_y, update_valid, hit_left, hit_right, wall_hit, score_left, score_right, running,
                 e_x, e_y, e_vx, e_vy, e_uv, e_hl, e_hr, e_wh, e_sl, e_sr, e_run);
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic drive_paddles();
    left_paddle_y = follow_l ? 16'(e_y >= 10 ? e_y - 10 : 0) : 16'(e_y < 240 ? 400 : 0);
    right_paddle_y = follow_r ? 16'(e_y >= 10 ? e_y - 10 : 0) : 16'(e_y < 240 ? 400 : 0);
  endtask

  task automatic ticks(input int n);
    repeat (n) begin
      @(negedge clk);
      drive_paddles();
      frame_tick = 1'b1;
    end
    @(negedge clk);
    frame_tick = 1'b0;
  endtask

  task automatic run_until_stop(input int budget);
    int k;
    k = 0;
    while (running && k < budget) begin
      drive_paddles();
      frame_tick = 1'b1;
      @(negedge clk);
      k++;
    end
    frame_tick = 1'b0;
    chk("rally_bound", int'(running), 0);
  endtask

  task automatic do_serve();
    @(negedge clk);
    serve = 1'b1;
    @(negedge clk);
    serve = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(negedge clk);
    rst = 1'b1;
    chk_en = 1;
    chk("rst_x", ball_x, 320);
    chk("rst_y", ball_y, 240);
    chk("rst_vx", vel_x, 0);
    chk("rst_run", running, 0);
    chk("rst_score", score_left + score_right, 0);
    do_serve();
    chk("serve_run", running, 1);
    chk("serve_x", ball_x, 320);
    chk("serve_vx", vel_x, 2);
    chk("serve_vy", vel_y, 1);
    ticks(1);
    chk("tick1_x", ball_x, 322);
    chk("tick1_y", ball_y, 241);
    chk("tick1_uv", update_valid, 1);
    @(negedge clk);
    chk("tick1_uv_drop", update_valid, 0);
    ticks(151);
    chk("rhit_x", ball_x, 623);
    chk("rhit_y", ball_y, 392);
    chk("rhit_pulse", hit_right, 1);
`ifdef PONG_SPEEDUP_EN
    chk("rhit_vx", vel_x, -3);
`else
    chk("rhit_vx", vel_x, -2);
`endif
    ticks(87);
`ifndef PONG_SPEEDUP_EN
    chk("pre_wall_y", ball_y, 479);
    chk("pre_wall_x", ball_x, 449);
`endif
    ticks(1);
`ifndef PONG_SPEEDUP_EN
    chk("wall_y", ball_y, 479);
    chk("wall_vy", vel_y, -1);
    chk("wall_pulse", wall_hit, 1);
`endif
    ticks(215);
`ifndef PONG_SPEEDUP_EN
    chk("pre_lhit_x", ball_x, 17);
    chk("pre_lhit_y", ball_y, 264);
`endif
    ticks(1);
`ifndef PONG_SPEEDUP_EN
    chk("lhit_x", ball_x, 16);
    chk("lhit_vx", vel_x, 2);
    chk("lhit_pulse", hit_left, 1);
    chk("lhit_y", ball_y, 263);
`endif
    follow_l = 0;
    run_until_stop(3000);
    chk("miss_score_r", score_right, 1);
    chk("miss_score_l", score_left, 0);
`ifndef PONG_SPEEDUP_EN
    chk("miss_frozen_x", ball_x, 17);
    chk("miss_frozen_y", ball_y, 343);
`endif
    ticks(3);
    chk("scored_no_uv", update_valid, 0);
    chk("scored_run", running, 0);
`ifndef PONG_SPEEDUP_EN
    chk("scored_x", ball_x, 17);
`endif
    do_serve();
    chk("reserve_vx", vel_x, -2);
    chk("reserve_x", ball_x, 320);
    repeat (16) begin
      run_until_stop(3000);
      do_serve();
    end
    chk("sat_score_r", score_right, 15);
    ticks(5);
    @(negedge clk);
    rst = 1'b0;
    frame_tick = 1'b1;
    @(negedge clk);
    rst = 1'b1;
    frame_tick = 1'b0;
    chk("mid_rst_x", ball_x, 320);
    chk("mid_rst_y", ball_y, 240);
    chk("mid_rst_vx", vel_x, 0);
    chk("mid_rst_vy", vel_y, 0);
    chk("mid_rst_score_r", score_right, 0);
    chk("mid_rst_run", running, 0);
    chk("mid_rst_uv", update_valid, 0);
    follow_l = 1;
    follow_r = 0;
    do_serve();
    chk("post_rst_serve_vx", vel_x, 2);
    run_until_stop(3000);
    chk("rmiss_score_l", score_left, 1);
    chk("rmiss_score_r", score_right, 0);
    chk("rmiss_x", ball_x, 622);
    chk("rmiss_y", ball_y, 391);
    do_serve();
    chk("rmiss_serve_vx", vel_x, 2);
    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
